// File: rtl/core_axi_bridge_if.sv
// AXI4-Lite master-side bundle shared by the core bus bridge and its slave.
// Signal names keep the m_ prefix so waveforms match the bridge's port list.
interface core_axi_bridge_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = 8
) ();
    logic              m_awvalid;
    logic              m_awready;
    logic [ADDR_W-1:0] m_awaddr;

    logic              m_wvalid;
    logic              m_wready;
    logic [DATA_W-1:0] m_wdata;
    logic [STRB_W-1:0] m_wstrb;

    logic              m_bvalid;
    logic              m_bready;
    logic [1:0]        m_bresp;

    logic              m_arvalid;
    logic              m_arready;
    logic [ADDR_W-1:0] m_araddr;

    logic              m_rvalid;
    logic              m_rready;
    logic [DATA_W-1:0] m_rdata;
    logic [1:0]        m_rresp;

    modport master (
        output m_awvalid, m_awaddr,
        output m_wvalid, m_wdata, m_wstrb,
        output m_bready,
        output m_arvalid, m_araddr,
        output m_rready,
        input  m_awready, m_wready,
        input  m_bvalid, m_bresp,
        input  m_arready,
        input  m_rvalid, m_rdata, m_rresp
    );

    modport slave (
        input  m_awvalid, m_awaddr,
        input  m_wvalid, m_wdata, m_wstrb,
        input  m_bready,
        input  m_arvalid, m_araddr,
        input  m_rready,
        output m_awready, m_wready,
        output m_bvalid, m_bresp,
        output m_arready,
        output m_rvalid, m_rdata, m_rresp
    );
endinterface

// File: rtl/core_axi_bridge.sv
// Turns the core's fetch/load/store requests into single-beat AXI4-Lite
// transactions, one at a time, with data accesses ahead of fetches.
module core_axi_bridge #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int INSTR_W = 32,
    parameter int STRB_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               instr_rd_en_i,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic               mem_rd_en_i,
    input  logic [ADDR_W-1:0]  addr_mem_rd_i,
    input  logic               mem_wr_en_i,
    input  logic [ADDR_W-1:0]  addr_mem_wr_i,
    input  logic [DATA_W-1:0]  data_mem_wr_i,
    input  logic [STRB_W-1:0]  strb_mem_wr_i,

    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  addr_instr_o,
    output logic [DATA_W-1:0]  data_mem_o,
    output logic               stall_if,
    output logic               stall_mem,
    output logic               bus_err_o,

    core_axi_bridge_if.master  axi
);

    localparam int LANES    = DATA_W / INSTR_W;
    localparam int LANE_W   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int LANE_LSB = $clog2(INSTR_W / 8);
    localparam logic [INSTR_W-1:0] NOP = INSTR_W'(32'h0000_0013);

    typedef enum logic [3:0] {
        IDLE,
        D_WR,
        D_WR_RESP,
        D_RD_ADDR,
        D_RD_DATA,
        I_RD_ADDR,
        I_RD_DATA,
        DONE_D,
        DONE_I
    } state_t;

    state_t              state_reg, state_next;

    logic                awvalid_reg, awvalid_next;
    logic                wvalid_reg, wvalid_next;
    logic                bready_reg, bready_next;
    logic                arvalid_reg, arvalid_next;
    logic                rready_reg, rready_next;
    logic [ADDR_W-1:0]   awaddr_reg, awaddr_next;
    logic [ADDR_W-1:0]   araddr_reg, araddr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [STRB_W-1:0]   wstrb_reg, wstrb_next;

    logic [INSTR_W-1:0]  instr_reg, instr_next;
    logic [ADDR_W-1:0]   addr_instr_reg, addr_instr_next;
    logic [DATA_W-1:0]   data_mem_reg, data_mem_next;
    logic                bus_err_reg, bus_err_next;

    logic                aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [INSTR_W-1:0]  rd_lane [LANES];
    logic [LANE_W-1:0]   lane_sel;

    assign aw_hs = awvalid_reg & axi.m_awready;
    assign w_hs  = wvalid_reg  & axi.m_wready;
    assign b_hs  = bready_reg  & axi.m_bvalid;
    assign ar_hs = arvalid_reg & axi.m_arready;
    assign r_hs  = rready_reg  & axi.m_rvalid;

    // Split the read beat into instruction-sized lanes; the fetch address
    // (held in araddr_reg) picks which lane is the instruction.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign rd_lane[gi] = axi.m_rdata[gi*INSTR_W +: INSTR_W];
        end
    endgenerate

    assign lane_sel = araddr_reg[LANE_LSB +: LANE_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            awvalid_reg    <= 1'b0;
            wvalid_reg     <= 1'b0;
            bready_reg     <= 1'b0;
            arvalid_reg    <= 1'b0;
            rready_reg     <= 1'b0;
            awaddr_reg     <= '0;
            araddr_reg     <= '0;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
            instr_reg      <= NOP;
            addr_instr_reg <= '0;
            data_mem_reg   <= '0;
            bus_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            awvalid_reg    <= awvalid_next;
            wvalid_reg     <= wvalid_next;
            bready_reg     <= bready_next;
            arvalid_reg    <= arvalid_next;
            rready_reg     <= rready_next;
            awaddr_reg     <= awaddr_next;
            araddr_reg     <= araddr_next;
            wdata_reg      <= wdata_next;
            wstrb_reg      <= wstrb_next;
            instr_reg      <= instr_next;
            addr_instr_reg <= addr_instr_next;
            data_mem_reg   <= data_mem_next;
            bus_err_reg    <= bus_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        awvalid_next    = awvalid_reg;
        wvalid_next     = wvalid_reg;
        bready_next     = bready_reg;
        arvalid_next    = arvalid_reg;
        rready_next     = rready_reg;
        awaddr_next     = awaddr_reg;
        araddr_next     = araddr_reg;
        wdata_next      = wdata_reg;
        wstrb_next      = wstrb_reg;
        instr_next      = instr_reg;
        addr_instr_next = addr_instr_reg;
        data_mem_next   = data_mem_reg;
        bus_err_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (mem_wr_en_i) begin
                    state_next   = D_WR;
                    awaddr_next  = addr_mem_wr_i;
                    wdata_next   = data_mem_wr_i;
                    wstrb_next   = strb_mem_wr_i;
                    awvalid_next = 1'b1;
                    wvalid_next  = 1'b1;
                end else if (mem_rd_en_i) begin
                    state_next   = D_RD_ADDR;
                    araddr_next  = addr_mem_rd_i;
                    arvalid_next = 1'b1;
                end else if (instr_rd_en_i) begin
                    state_next   = I_RD_ADDR;
                    araddr_next  = pc_i;
                    arvalid_next = 1'b1;
                end
            end

            // AW and W complete independently; a channel already done counts as done.
            D_WR: begin
                if (aw_hs) awvalid_next = 1'b0;
                if (w_hs)  wvalid_next  = 1'b0;
                if ((aw_hs || !awvalid_reg) && (w_hs || !wvalid_reg)) begin
                    state_next  = D_WR_RESP;
                    bready_next = 1'b1;
                end
            end

            D_WR_RESP: begin
                if (b_hs) begin
                    bready_next  = 1'b0;
                    bus_err_next = |axi.m_bresp;
                    state_next   = DONE_D;
                end
            end

            D_RD_ADDR, I_RD_ADDR: begin
                if (ar_hs) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = (state_reg == D_RD_ADDR) ? D_RD_DATA : I_RD_DATA;
                end
            end

            D_RD_DATA: begin
                if (r_hs) begin
                    rready_next   = 1'b0;
                    data_mem_next = axi.m_rdata;
                    bus_err_next  = |axi.m_rresp;
                    state_next    = DONE_D;
                end
            end

            I_RD_DATA: begin
                if (r_hs) begin
                    rready_next     = 1'b0;
                    instr_next      = rd_lane[lane_sel];
                    addr_instr_next = araddr_reg;
                    bus_err_next    = |axi.m_rresp;
                    state_next      = DONE_I;
                end
            end

            DONE_D, DONE_I: state_next = IDLE;

            default: state_next = IDLE;
        endcase
    end

    // Stalls follow the live request lines, so a dropped request stops stalling at once.
    assign stall_mem = (mem_rd_en_i | mem_wr_en_i) & (state_reg != DONE_D);
    assign stall_if  = instr_rd_en_i & (state_reg != DONE_I);

    assign instr_o      = instr_reg;
    assign addr_instr_o = addr_instr_reg;
    assign data_mem_o   = data_mem_reg;
    assign bus_err_o    = bus_err_reg;

    assign axi.m_awvalid = awvalid_reg;
    assign axi.m_awaddr  = awaddr_reg;
    assign axi.m_wvalid  = wvalid_reg;
    assign axi.m_wdata   = wdata_reg;
    assign axi.m_wstrb   = wstrb_reg;
    assign axi.m_bready  = bready_reg;
    assign axi.m_arvalid = arvalid_reg;
    assign axi.m_araddr  = araddr_reg;
    assign axi.m_rready  = rready_reg;

endmodule

// File: tb/tb_core_axi_bridge.sv
// Bench for core_axi_bridge: a scheduled core model plus a delay-driven AXI slave,
// with stall timing predicted from transaction latencies.
module tb_core_axi_bridge;

    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int INSTR_W = 32;
    localparam int STRB_W  = 8;

    localparam int K_WR = 0;
    localparam int K_RD = 1;
    localparam int K_IF = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               instr_rd_en_i = 1'b0;
    logic [ADDR_W-1:0]  pc_i = '0;
    logic               mem_rd_en_i = 1'b0;
    logic [ADDR_W-1:0]  addr_mem_rd_i = '0;
    logic               mem_wr_en_i = 1'b0;
    logic [ADDR_W-1:0]  addr_mem_wr_i = '0;
    logic [DATA_W-1:0]  data_mem_wr_i = '0;
    logic [STRB_W-1:0]  strb_mem_wr_i = '0;
    logic [INSTR_W-1:0] instr_o;
    logic [ADDR_W-1:0]  addr_instr_o;
    logic [DATA_W-1:0]  data_mem_o;
    logic               stall_if;
    logic               stall_mem;
    logic               bus_err_o;

    core_axi_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) axi ();

    core_axi_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INSTR_W(INSTR_W), .STRB_W(STRB_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_rd_en_i (instr_rd_en_i),
        .pc_i          (pc_i),
        .mem_rd_en_i   (mem_rd_en_i),
        .addr_mem_rd_i (addr_mem_rd_i),
        .mem_wr_en_i   (mem_wr_en_i),
        .addr_mem_wr_i (addr_mem_wr_i),
        .data_mem_wr_i (data_mem_wr_i),
        .strb_mem_wr_i (strb_mem_wr_i),
        .instr_o       (instr_o),
        .addr_instr_o  (addr_instr_o),
        .data_mem_o    (data_mem_o),
        .stall_if      (stall_if),
        .stall_mem     (stall_mem),
        .bus_err_o     (bus_err_o),
        .axi           (axi)
    );

    // One request as the core sees it, plus how slowly the slave answers it.
    typedef struct {
        int          kind;
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [1:0]  resp;
        int          d_a;
        int          d_w;
        int          d_r;
    } item_t;

    item_t it [2];
    int    n_it;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_txn    = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic item_t mk(input int kind, input logic [63:0] addr, input logic [63:0] data,
                                 input logic [7:0] strb, input logic [1:0] resp,
                                 input int d_a, input int d_w, input int d_r);
        item_t x;
        x.kind = kind; x.addr = addr; x.data = data; x.strb = strb; x.resp = resp;
        x.d_a = d_a; x.d_w = d_w; x.d_r = d_r;
        return x;
    endfunction

    // Every request is raised at cycle 0 and held until its own completion cycle.
    // Completion = start + 3 + address/data wait + response wait; the next queued
    // request starts in the cycle after the previous completion.
    task automatic run_sched();
        int done_c [2];
        int start, last, cur, ci;
        int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
        bit r_pend, b_pend, aw_done, w_done;
        int n_ar, n_r, n_aw, n_w, n_b;
        logic p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_rv, p_rr, p_bv, p_br;
        logic [63:0] p_araddr, p_awaddr, p_wdata;
        logic [7:0]  p_wstrb;
        bit want_sm, want_si, want_err;
        logic [31:0] exp_instr;

        start = 0;
        for (int k = 0; k < n_it; k++) begin
            done_c[k] = start + 3 + it[k].d_r +
                        ((it[k].kind == K_WR && it[k].d_w > it[k].d_a) ? it[k].d_w : it[k].d_a);
            start = done_c[k] + 1;
        end
        last = done_c[n_it-1];
        cur = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
        r_pend = 0; b_pend = 0; aw_done = 0; w_done = 0;
        n_ar = 0; n_r = 0; n_aw = 0; n_w = 0; n_b = 0;
        p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
        p_rv = 0; p_rr = 0; p_bv = 0; p_br = 0;
        p_araddr = '0; p_awaddr = '0; p_wdata = '0; p_wstrb = '0;

        for (int c = 0; c <= last + 1; c++) begin
            @(posedge clk);
            #1;
            ci = (cur < n_it) ? cur : n_it - 1;

            if (p_arv && p_arr) begin
                check_eq("araddr", p_araddr, it[ci].addr);
                n_ar++; ar_cnt = 0; r_pend = 1; r_cnt = 0;
            end
            if (p_arv && !p_arr) check_eq("ar_hold", {axi.m_arvalid, axi.m_araddr}, {1'b1, p_araddr});
            if (p_awv && p_awr) begin
                check_eq("awaddr", p_awaddr, it[ci].addr);
                n_aw++; aw_cnt = 0; aw_done = 1;
            end
            if (p_awv && !p_awr) check_eq("aw_hold", {axi.m_awvalid, axi.m_awaddr}, {1'b1, p_awaddr});
            if (p_wv && p_wr) begin
                check_eq("w_payload", {p_wdata, p_wstrb}, {it[ci].data, it[ci].strb});
                n_w++; w_cnt = 0; w_done = 1;
            end
            if (p_wv && !p_wr)
                check_eq("w_hold", {axi.m_wvalid, axi.m_wdata, axi.m_wstrb}, {1'b1, p_wdata, p_wstrb});
            if (aw_done && w_done) begin
                aw_done = 0; w_done = 0; b_pend = 1; b_cnt = 0;
            end
            if (p_rv && p_rr) begin n_r++; r_pend = 0; end
            if (p_bv && p_br) begin n_b++; b_pend = 0; end

            mem_wr_en_i = 1'b0; mem_rd_en_i = 1'b0; instr_rd_en_i = 1'b0;
            for (int k = 0; k < n_it; k++) begin
                if (c <= done_c[k]) begin
                    case (it[k].kind)
                        K_WR: begin
                            mem_wr_en_i = 1'b1; addr_mem_wr_i = it[k].addr;
                            data_mem_wr_i = it[k].data; strb_mem_wr_i = it[k].strb;
                        end
                        K_RD: begin mem_rd_en_i = 1'b1; addr_mem_rd_i = it[k].addr; end
                        default: begin instr_rd_en_i = 1'b1; pc_i = it[k].addr; end
                    endcase
                end
            end

            axi.m_arready = axi.m_arvalid && (ar_cnt >= it[ci].d_a);
            if (axi.m_arvalid) ar_cnt++;
            axi.m_awready = axi.m_awvalid && (aw_cnt >= it[ci].d_a);
            if (axi.m_awvalid) aw_cnt++;
            axi.m_wready = axi.m_wvalid && (w_cnt >= it[ci].d_w);
            if (axi.m_wvalid) w_cnt++;
            axi.m_rvalid = r_pend && (r_cnt >= it[ci].d_r);
            if (r_pend) r_cnt++;
            axi.m_rdata = axi.m_rvalid ? it[ci].data : '0;
            axi.m_rresp = axi.m_rvalid ? it[ci].resp : 2'b00;
            axi.m_bvalid = b_pend && (b_cnt >= it[ci].d_r);
            if (b_pend) b_cnt++;
            axi.m_bresp = axi.m_bvalid ? it[ci].resp : 2'b00;

            p_arv = axi.m_arvalid; p_arr = axi.m_arready; p_araddr = axi.m_araddr;
            p_awv = axi.m_awvalid; p_awr = axi.m_awready; p_awaddr = axi.m_awaddr;
            p_wv = axi.m_wvalid; p_wr = axi.m_wready; p_wdata = axi.m_wdata; p_wstrb = axi.m_wstrb;
            p_rv = axi.m_rvalid; p_rr = axi.m_rready;
            p_bv = axi.m_bvalid; p_br = axi.m_bready;

            @(negedge clk);
            want_sm = 0; want_si = 0; want_err = 0;
            for (int k = 0; k < n_it; k++) begin
                if (c < done_c[k]) begin
                    if (it[k].kind == K_IF) want_si = 1;
                    else want_sm = 1;
                end
                if (c == done_c[k] && it[k].resp != 2'b00) want_err = 1;
            end
            check_eq("stall_mem", stall_mem, want_sm);
            check_eq("stall_if", stall_if, want_si);
            check_eq("bus_err", bus_err_o, want_err);

            for (int k = 0; k < n_it; k++) begin
                if (c == done_c[k]) begin
                    case (it[k].kind)
                        K_WR: check_eq("wr_handshakes",
                                       n_aw*10000 + n_w*1000 + n_b*100 + n_ar*10 + n_r, 11100);
                        K_RD: begin
                            check_eq("rd_handshakes",
                                     n_aw*10000 + n_w*1000 + n_b*100 + n_ar*10 + n_r, 11);
                            check_eq("data_mem_o", data_mem_o, it[k].data);
                        end
                        default: begin
                            check_eq("if_handshakes",
                                     n_aw*10000 + n_w*1000 + n_b*100 + n_ar*10 + n_r, 11);
                            exp_instr = it[k].addr[2] ? it[k].data[63:32] : it[k].data[31:0];
                            check_eq("instr_o", instr_o, exp_instr);
                            check_eq("addr_instr_o", addr_instr_o, it[k].addr);
                        end
                    endcase
                    $display("txn %0d kind=%0d addr=%h data=%h resp=%0d done_cycle=%0d",
                             n_txn, it[k].kind, it[k].addr, it[k].data, it[k].resp, c);
                    n_txn++;
                    cur++;
                    n_ar = 0; n_r = 0; n_aw = 0; n_w = 0; n_b = 0;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        axi.m_awready = 1'b0; axi.m_wready = 1'b0; axi.m_bvalid = 1'b0; axi.m_bresp = 2'b00;
        axi.m_arready = 1'b0; axi.m_rvalid = 1'b0; axi.m_rdata = '0; axi.m_rresp = 2'b00;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_ctrl",
                 {axi.m_awvalid, axi.m_wvalid, axi.m_bready, axi.m_arvalid, axi.m_rready, bus_err_o},
                 6'b0);
        check_eq("reset_instr", {instr_o, addr_instr_o}, {32'h0000_0013, 64'h0});
        check_eq("reset_data", {data_mem_o, axi.m_awaddr}, 128'h0);
        check_eq("reset_axi_regs", {axi.m_araddr, axi.m_wdata}, 128'h0);
        check_eq("reset_wstrb", axi.m_wstrb, 8'h0);
        rst_n = 1'b1;

        n_it = 1; it[0] = mk(K_IF, 64'h8000_0004, 64'h0050_0093_0000_0013, 8'h0, 2'b00, 0, 0, 0);
        run_sched();
        n_it = 1; it[0] = mk(K_WR, 64'h8000_1000, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 2'b00, 2, 0, 0);
        run_sched();
        n_it = 2;
        it[0] = mk(K_RD, 64'h8000_3008, 64'h1122_3344_5566_7788, 8'h0, 2'b00, 0, 0, 0);
        it[1] = mk(K_IF, 64'h8000_0010, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0, 2'b00, 0, 0, 0);
        run_sched();
        n_it = 1; it[0] = mk(K_RD, 64'h8000_4000, 64'h1234, 8'h0, 2'b10, 0, 0, 0);
        run_sched();
        n_it = 1; it[0] = mk(K_RD, 64'h8000_5010, 64'h0BAD_F00D_0000_0001, 8'h0, 2'b00, 5, 0, 0);
        run_sched();

        // Reset while the read data phase is open.
        @(posedge clk); #1;
        mem_rd_en_i = 1'b1; addr_mem_rd_i = 64'h8000_2000; axi.m_arready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("rready_before_rst", axi.m_rready, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_ctrl",
                 {axi.m_awvalid, axi.m_wvalid, axi.m_bready, axi.m_arvalid, axi.m_rready, bus_err_o},
                 6'b0);
        check_eq("async_rst_instr", {instr_o, addr_instr_o}, {32'h0000_0013, 64'h0});
        mem_rd_en_i = 1'b0; axi.m_arready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_it = 1; it[0] = mk(K_IF, 64'h8000_0100, 64'h0000_0033_00A0_0513, 8'h0, 2'b00, 0, 0, 0);
        run_sched();

        for (int t = 0; t < 40; t++) begin
            int sel;
            sel = $urandom_range(0, 3);
            for (int k = 0; k < 2; k++) begin
                it[k] = mk(K_RD, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom),
                           ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            end
            if (sel == 3) begin
                n_it = 2; it[1].kind = K_IF;
            end else begin
                n_it = 1; it[0].kind = sel;
            end
            run_sched();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_axi_bridge.md
Name: core_axi_bridge

Overview:
- Bus interface unit directly downstream of the pipeline core.
- Converts the core's instruction-fetch request and its data load/store requests into single-beat AXI4-Lite master transactions.
- Generates the core's stall_if / stall_mem handshake inputs.
- Returns fetched instruction and load data to the core. Data accesses take priority over instruction fetches on the shared master port.

Parameters:
ADDR_W, 64, width of core and AXI addresses
DATA_W, 64, width of AXI data bus and core load/store data
INSTR_W, 32, instruction width returned to core
STRB_W, 8, write strobe width (DATA_W/8)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
instr_rd_en_i  input  1  core fetch request
pc_i  input  ADDR_W  fetch address
mem_rd_en_i  input  1  core load request
addr_mem_rd_i  input  ADDR_W  load address
mem_wr_en_i  input  1  core store request
addr_mem_wr_i  input  ADDR_W  store address
data_mem_wr_i  input  DATA_W  store data
strb_mem_wr_i  input  STRB_W  store byte strobes
instr_o  output  INSTR_W  fetched instruction (registered)
addr_instr_o  output  ADDR_W  address of instr_o (registered)
data_mem_o  output  DATA_W  load data (registered)
stall_if  output  1  fetch not complete
stall_mem  output  1  data access not complete
bus_err_o  output  1  one-cycle pulse, nonzero RRESP/BRESP
m_awvalid, m_awready, m_awaddr[ADDR_W]  out/in/out  AXI write address
m_wvalid, m_wready, m_wdata[DATA_W], m_wstrb[STRB_W]  out/in/out/out  AXI write data
m_bvalid, m_bready, m_bresp[2]  in/out/in  AXI write response
m_arvalid, m_arready, m_araddr[ADDR_W]  out/in/out  AXI read address
m_rvalid, m_rready, m_rdata[DATA_W], m_rresp[2]  in/out/in/in  AXI read data

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - rst_n is asynchronous active-low.
  - Reset values: FSM=IDLE; all m_*valid, m_bready, m_rready, bus_err_o = 0; instr_o = 0x00000013 (NOP); addr_instr_o, data_mem_o, m_awaddr, m_araddr, m_wdata, m_wstrb = 0.
- FSM states: IDLE, D_WR, D_WR_RESP, D_RD_ADDR, D_RD_DATA, I_RD_ADDR, I_RD_DATA, DONE_D, DONE_I.
- IDLE arbitration, evaluated each cycle:
  - mem_wr_en_i → D_WR.
  - else mem_rd_en_i → D_RD_ADDR.
  - else instr_rd_en_i → I_RD_ADDR.
  - Address, data and strobe are captured into AXI registers on the transition.
- Writes:
  - D_WR: m_awvalid and m_wvalid both assert on entry. Each drops independently after its own handshake.
  - When both handshakes are done → D_WR_RESP with m_bready=1.
  - B handshake → DONE_D.
- Data reads:
  - D_RD_ADDR: m_arvalid=1 until the AR handshake → D_RD_DATA with m_rready=1.
  - R handshake: capture m_rdata into data_mem_o → DONE_D.
- Fetches:
  - I_RD_ADDR / I_RD_DATA behave like data reads.
  - On R handshake: instr_o = pc[2] ? m_rdata[63:32] : m_rdata[31:0]; addr_instr_o = captured pc → DONE_I.
- DONE states:
  - DONE_D / DONE_I last one cycle, then IDLE. No new request is accepted in a DONE state.
- Stall outputs (combinational):
  - stall_mem = (mem_rd_en_i | mem_wr_en_i) & (state != DONE_D).
  - stall_if = instr_rd_en_i & (state != DONE_I).
  - A fetch pending behind a data access keeps stall_if high until its own DONE_I.
- Minimum latency, with ready/valid returned the same cycle:
  - Request seen in IDLE at cycle 0; AR/AW valid at cycle 1; R/B at cycle 2; DONE and stall low at cycle 3.
  - Read = 3 cycles, write = 3 cycles.
- Address handling: m_araddr and m_awaddr pass through unmodified. No alignment or strobe rewriting is performed.
- Errors: nonzero m_rresp or m_bresp sets bus_err_o high for exactly the DONE cycle. Data is still delivered and no retry is made.
- Simultaneous mem_rd_en_i and mem_wr_en_i is not issued by the core. If it occurs, the write is served and DONE_D ends both stalls.
- Request dropped mid-transaction (e.g. core flush): the AXI transaction still completes. Its result is written to the output registers, but the stall equation no longer depends on it.
- Reset asserted mid-transaction: immediate return to reset values. The AXI slave shares the reset, so no transaction abort is performed.
- AXI rules:
  - valid never depends on ready.
  - Once asserted, valid and payload stay stable until the handshake.

Test Plan:
- Fetch, zero-wait slave: instr_rd_en_i=1, pc_i=0x80000004, rdata=0x00500093_00000013 → stall_if high cycles 0–2, instr_o=0x00500093, addr_instr_o=0x80000004 at cycle 3.
- Store with AW ready 2 cycles after W: addr=0x80001000, data=0xDEADBEEF_CAFEF00D, strb=0x0F → W dropped after its handshake, AW held until its own; stall_mem falls exactly in DONE_D; exactly one AW, W and B handshake.
- Load concurrent with fetch: mem_rd_en_i and instr_rd_en_i both high in IDLE → data AR issued first; stall_mem clears; then fetch AR issued; stall_if clears 3 cycles later.
- Error response: m_rresp=2'b10 on a load returning 0x1234 → bus_err_o one-cycle pulse in DONE_D; data_mem_o=0x1234.
- Back-pressure: arready low for 5 cycles → m_arvalid and m_araddr stable throughout; stall held; completion 5 cycles later than minimum.
- Reset during D_RD_DATA: rst_n low → all valid/ready low and FSM in IDLE asynchronously; after release, a new fetch completes normally.
